hazard_ctrl: RTL and testbench



---
 rtl/riscv_pkg.sv | 13 +
 rtl/load_use_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: hazard FSM states and register-file sizing.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the EX load writes a register the ID instruction reads.
// Writes to x0 are discarded by the register file, so they never create a hazard.
module load_use_detect #(
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] IdRs1,
    input  logic [REG_ADDR_W-1:0] IdRs2,
    input  logic                  IdUsesRs1,
    input  logic                  IdUsesRs2,
    input  logic [REG_ADDR_W-1:0] ExRd,
    input  logic                  ExMemRead,
    output logic                  LoadUse
);
    import riscv_pkg::X0;

    // Pure compare; no state is needed because the load leaves EX next cycle.
    always_comb begin
        LoadUse = ExMemRead & (ExRd != REG_ADDR_W'(X0)) &
                  ((IdUsesRs1 & (ExRd == IdRs1)) | (IdUsesRs2 & (ExRd == IdRs2)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline.
// Outputs are combinational from registered FSM state plus current inputs so a
// hazard acts in the cycle it is seen. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_ADDR_W     = riscv_pkg::REG_ADDR_W,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] IdRs1,
    input  logic [REG_ADDR_W-1:0] IdRs2,
    input  logic                  IdUsesRs1,
    input  logic                  IdUsesRs2,
    input  logic [REG_ADDR_W-1:0] ExRd,
    input  logic                  ExMemRead,
    input  logic                  BranchTaken,
    input  logic                  MemBusy,
    output logic                  MuxControlEn,
    output logic                  ControlHazard,
    output logic                  IdExFlush,
    output logic                  PcWriteEn,
    output logic [CNT_W-1:0]      StallCycles,
    output logic [CNT_W-1:0]      FlushCycles
);
    import riscv_pkg::*;

    // Remaining extra flush cycles after the one taken in the branch cycle itself.
    localparam logic [2:0] RELOAD = 3'(BRANCH_PENALTY - 1);
    localparam bit         MULTI  = (BRANCH_PENALTY > 1);

    hazard_state_t state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          lu;
    logic          mce, ch, ief;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
        .IdRs1     (IdRs1),
        .IdRs2     (IdRs2),
        .IdUsesRs1 (IdUsesRs1),
        .IdUsesRs2 (IdUsesRs2),
        .ExRd      (ExRd),
        .ExMemRead (ExMemRead),
        .LoadUse   (lu)
    );

    // Next-state and hazard decisions; branch beats memory wait beats load-use.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        mce     = 1'b0;
        ch      = 1'b0;
        ief     = 1'b0;
        case (state_q)
            RUN: begin
                if (BranchTaken) begin
                    ch  = 1'b1;
                    ief = 1'b1;
                    if (MULTI) begin
                        state_d = FLUSH;
                        cnt_d   = RELOAD;
                    end
                end else if (MemBusy) begin
                    mce     = 1'b1;
                    state_d = MEMWAIT;
                end else if (lu) begin
                    mce = 1'b1;
                    ief = 1'b1;
                end
            end
            FLUSH: begin
                // ID is being cleared, so load-use is irrelevant here.
                ch  = 1'b1;
                ief = 1'b1;
                if (MemBusy) begin
                    // Remember the branch so the full penalty replays after the wait.
                    mce     = 1'b1;
                    state_d = MEMWAIT;
                    pend_d  = 1'b1;
                end else if (BranchTaken) begin
                    cnt_d = RELOAD;
                end else if (cnt_q == 3'd1) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            MEMWAIT: begin
                if (MemBusy) begin
                    mce = 1'b1;
                    ief = 1'b1;
                    if (BranchTaken) pend_d = 1'b1;
                end else if (pend_q | BranchTaken) begin
                    // Memory ready: the pipe moves again and the deferred flush starts.
                    ch     = 1'b1;
                    ief    = 1'b1;
                    pend_d = 1'b0;
                    if (MULTI) begin
                        state_d = FLUSH;
                        cnt_d   = RELOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                    if (lu) begin
                        mce = 1'b1;
                        ief = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // FSM state, branch-penalty counter and pending-branch flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Reset gates the outputs directly so they drop while rst is low.
    assign MuxControlEn  = rst & mce;
    assign ControlHazard = rst & ch;
    assign IdExFlush     = rst & ief;
    assign PcWriteEn     = rst & ~mce;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Free-running stall/flush cycle counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (mce) stall_q <= stall_q + CNT_W'(1);
            if (ch)  flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign StallCycles = stall_q;
    assign FlushCycles = flush_q;
`else
    assign StallCycles = '0;
    assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (BRANCH_PENALTY=2). Expected output vectors
// {MuxControlEn, ControlHazard, IdExFlush, PcWriteEn} are queued when a step is
// driven and popped/compared once the combinational outputs settle.
module tb_hazard_ctrl;

    localparam int W     = 5;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     IdRs1, IdRs2, ExRd;
    logic             IdUsesRs1, IdUsesRs2, ExMemRead, BranchTaken, MemBusy;
    logic             MuxControlEn, ControlHazard, IdExFlush, PcWriteEn;
    logic [CNT_W-1:0] StallCycles, FlushCycles;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    hazard_ctrl #(.REG_ADDR_W(W), .BRANCH_PENALTY(2), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .IdRs1         (IdRs1),
        .IdRs2         (IdRs2),
        .IdUsesRs1     (IdUsesRs1),
        .IdUsesRs2     (IdUsesRs2),
        .ExRd          (ExRd),
        .ExMemRead     (ExMemRead),
        .BranchTaken   (BranchTaken),
        .MemBusy       (MemBusy),
        .MuxControlEn  (MuxControlEn),
        .ControlHazard (ControlHazard),
        .IdExFlush     (IdExFlush),
        .PcWriteEn     (PcWriteEn),
        .StallCycles   (StallCycles),
        .FlushCycles   (FlushCycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle();
        BranchTaken = 0; MemBusy = 0; ExMemRead = 0; ExRd = 0;
        IdRs1 = 0; IdRs2 = 0; IdUsesRs1 = 0; IdUsesRs2 = 0;
    endtask

    // Called at a negedge after inputs are driven; checks mid-cycle, returns at next negedge.
    task automatic step(input logic [3:0] exp, input string tag);
        sb_t e, got;
        logic [3:0] obs;
        e.tag = tag; e.exp = exp;
        sb.push_back(e);
        #2;
        obs = {MuxControlEn, ControlHazard, IdExFlush, PcWriteEn};
        got = sb.pop_front();
        checks++;
        assert (obs === got.exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", got.tag, obs, got.exp);
        end
        @(negedge clk);
    endtask

    task automatic chk_cnt(input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [CNT_W-1:0] exp_stall;
        // Reset with hazard-causing inputs active: all outputs must be 0.
        idle();
        rst = 0; BranchTaken = 1; ExMemRead = 1; ExRd = 5; IdRs1 = 5; IdUsesRs1 = 1;
        step(4'b0000, "reset_outputs");
        chk_cnt(StallCycles, '0, "reset_stallcnt");
        chk_cnt(FlushCycles, '0, "reset_flushcnt");
        rst = 1; idle();
        step(4'b0001, "idle_after_reset");

        // Load-use on rs1: one-cycle stall + bubble.
        ExMemRead = 1; ExRd = 5; IdRs1 = 5; IdUsesRs1 = 1;
        step(4'b1010, "lu_rs1");
        ExMemRead = 0;
        step(4'b0001, "lu_cleared");
`ifdef HAZARD_PERF_CNT_EN
        exp_stall = 1;
`else
        exp_stall = 0;
`endif
        chk_cnt(StallCycles, exp_stall, "stallcnt_after_lu");
        chk_cnt(FlushCycles, '0, "flushcnt_after_lu");

        // Load to x0 never stalls.
        ExMemRead = 1; ExRd = 0; IdRs1 = 0; IdUsesRs1 = 1;
        step(4'b0001, "lu_x0");

        // Load-use on rs2; then rs2 matches but is not read.
        idle(); ExMemRead = 1; ExRd = 7; IdRs1 = 3; IdRs2 = 7; IdUsesRs1 = 1; IdUsesRs2 = 1;
        step(4'b1010, "lu_rs2");
        IdUsesRs2 = 0;
        step(4'b0001, "lu_rs2_unused");

        // Branch pulse: exactly two flush cycles, PC keeps writing.
        idle(); BranchTaken = 1;
        step(4'b0111, "br_cycle0");
        BranchTaken = 0;
        step(4'b0111, "br_cycle1");
        step(4'b0001, "br_done");

        // MemBusy for 3 cycles with a branch in cycle 2.
        MemBusy = 1;
        step(4'b1000, "mw_c1");
        BranchTaken = 1;
        step(4'b1010, "mw_c2_branch");
        BranchTaken = 0;
        step(4'b1010, "mw_c3");
        MemBusy = 0;
        step(4'b0111, "mw_pending_flush0");
        step(4'b0111, "mw_pending_flush1");
        step(4'b0001, "mw_done");

        // Branch and load-use together: branch wins; LU ignored in FLUSH.
        BranchTaken = 1; ExMemRead = 1; ExRd = 9; IdRs1 = 9; IdUsesRs1 = 1;
        step(4'b0111, "br_lu_same");
        BranchTaken = 0;
        step(4'b0111, "flush_ignores_lu");
        idle();
        step(4'b0001, "br_lu_done");

        // Memory wait arriving during FLUSH defers the branch penalty.
        BranchTaken = 1;
        step(4'b0111, "fm_branch");
        BranchTaken = 0; MemBusy = 1;
        step(4'b1110, "fm_flush_busy");
        step(4'b1010, "fm_memwait");
        MemBusy = 0;
        step(4'b0111, "fm_replay0");
        step(4'b0111, "fm_replay1");
        step(4'b0001, "fm_done");

        // Branch inside FLUSH reloads the counter.
        BranchTaken = 1;
        step(4'b0111, "rl_br0");
        step(4'b0111, "rl_br1_reload");
        BranchTaken = 0;
        step(4'b0111, "rl_tail");
        step(4'b0001, "rl_done");

        // Memory wait with no branch simply resumes.
        MemBusy = 1;
        step(4'b1000, "mw2_c1");
        step(4'b1010, "mw2_c2");
        MemBusy = 0;
        step(4'b0001, "mw2_release");

        // Async reset in the middle of FLUSH.
        BranchTaken = 1;
        step(4'b0111, "rf_branch");
        BranchTaken = 0; rst = 0;
        step(4'b0000, "rf_reset_low");
        chk_cnt(StallCycles, '0, "rf_stallcnt_cleared");
        chk_cnt(FlushCycles, '0, "rf_flushcnt_cleared");
        rst = 1;
        step(4'b0001, "rf_back_in_run");

        // Reset in the middle of MEMWAIT.
        MemBusy = 1;
        step(4'b1000, "rm_busy");
        rst = 0;
        step(4'b0000, "rm_reset_low");
        rst = 1; MemBusy = 0;
        step(4'b0001, "rm_back_in_run");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
